fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum imem wait cycles before fetch error.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; SHALL be this exactly.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address, equal to pc.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instruction  output  32  instruction presented to decoder/register file.
REQ-010 instr_valid  output  1  instruction holds a valid word.
REQ-011 instr_ready  input  1  CPU accepts (retires) instruction this cycle.
REQ-012 pc / pc_plus4  output  32 each  address of presented instruction / pc+4 (for jal return address).
REQ-013 branch_taken  input  1; branch_offset  input  16  branch decision and raw immediate.
REQ-014 jump  input  1; jump_index  input  26  j/jal target field.
REQ-015 jr  input  1; jr_target  input  32  register jump target.
REQ-016 fetch_err  output  1  sticky imem timeout; misalign_err  output  1  one-cycle pulse.

Function
REQ-017 FSM states IDLE, REQ, HOLD, ERR SHALL exist; IDLE lasts exactly one cycle after rst_n deassertion, then REQ.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr stable; imem_ack SHALL capture imem_rdata into instruction and move to HOLD next edge; ack on the first REQ cycle is legal (one-cycle fetch).
REQ-019 In REQ, a wait counter SHALL increment per cycle without ack; reaching TIMEOUT SHALL go to ERR.
REQ-020 ERR SHALL hold imem_req=0, instr_valid=0, fetch_err=1 until reset.
REQ-021 In HOLD, instr_valid SHALL be 1 and instruction/pc stable until instr_valid&&instr_ready, then the next edge SHALL load next pc and enter REQ.
REQ-022 Redirect inputs SHALL be sampled only on the accept cycle (instr_valid&&instr_ready); otherwise ignored.
REQ-023 Next pc priority: jr > jump > branch_taken > sequential.
REQ-024 Sequential: pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-025 Branch: pc_plus4 + (sign-extended branch_offset << 2), modulo 2^32.
REQ-026 Jump: {pc_plus4[31:28], jump_index, 2'b00}.
REQ-027 jr: {jr_target[31:2], 2'b00}; jr_target[1:0]!=0 SHALL pulse misalign_err for the accept cycle only.
REQ-028 imem_ack outside REQ SHALL be ignored.
REQ-029 Throughput: one instruction per two cycles with zero-wait memory (REQ, HOLD alternating).

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, pc=RESET_PC, pc_plus4=RESET_PC+4, instruction=0, instr_valid=0, imem_req=0, fetch_err=0, misalign_err=0, wait counter=0.
REQ-031 Reset mid-fetch SHALL abandon the outstanding request; a late ack after release SHALL be ignored (IDLE).

Structure
REQ-032 FSM state encoding, RESET_PC default and the 32'd4 increment SHALL live in the shared CPU package.
REQ-033 Next-pc selection SHALL be one sub-module, next_pc_logic (combinational, REQ-023..027); FSM, counter and registers stay in fetch_unit.

Verification
REQ-034 Reset release, imem always ack -> imem_addr 0,4,8,...; instr_valid every other cycle; pc_plus4=pc+4.
REQ-035 At pc=0x100, branch_taken=1, branch_offset=16'hFFFE on accept -> next imem_addr 0x0FC.
REQ-036 pc=0x4000_0010, jump=1, jump_index=26'h000_0040 and branch_taken=1 same cycle -> next addr 0x4000_0100 (jump wins).
REQ-037 jr=1, jr_target=0x203 -> next addr 0x200, misalign_err high exactly one cycle.
REQ-038 imem_ack held 0 -> fetch_err=1 after 15 REQ cycles, imem_req=0 thereafter; rst_n pulse -> clean restart at RESET_PC.
REQ-039 rst_n asserted while in REQ with ack arriving the cycle after release -> instruction stays 0, instr_valid 0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: fetch FSM encoding, reset PC and PC increment.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2,
        StErr  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
    localparam logic [31:0] PcIncr         = 32'd4;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jr > jump > branch > sequential.
module next_pc_logic (
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        jr_misalign
);

    logic [31:0] branch_disp;

    // Sign-extended word offset, already shifted to a byte displacement.
    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    // Priority select of the redirect target.
    always_comb begin
        next_pc     = pc_plus4;
        jr_misalign = 1'b0;
        if (jr) begin
            next_pc     = {jr_target[31:2], 2'b00};
            jr_misalign = (jr_target[1:0] != 2'b00);
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_disp;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, holds the fetched word
// until the CPU accepts it, then redirects or advances the PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPcDefault,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        fetch_err,
    output logic        misalign_err
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Value of the wait counter on the last no-ack REQ cycle allowed.
    localparam logic [CntW-1:0] WaitLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [CntW-1:0] wait_q, wait_d;

    logic [31:0] next_pc;
    logic        jr_misalign;
    logic        accept;

    assign pc_plus4 = pc_q + PcIncr;
    assign accept   = (state_q == StHold) && instr_ready;

    next_pc_logic u_next_pc_logic (
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .next_pc       (next_pc),
        .jr_misalign   (jr_misalign)
    );

    // Next-state logic for the fetch FSM, wait counter, PC and instruction.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                wait_d  = '0;
            end
            StReq: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StHold;
                    wait_d  = '0;
                end else if (wait_q == WaitLast) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            StHold: begin
                if (accept) begin
                    pc_d    = next_pc;
                    state_d = StReq;
                    wait_d  = '0;
                end
            end
            StErr: begin
                // Sticky until reset.
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

    assign imem_req     = (state_q == StReq);
    assign imem_addr    = pc_q;
    assign instruction  = instr_q;
    assign instr_valid  = (state_q == StHold);
    assign pc           = pc_q;
    assign fetch_err    = (state_q == StErr);
    // Redirect inputs only matter on the accept cycle, so the pulse is one cycle.
    assign misalign_err = accept && jr && jr_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetches
// checked against a transaction-level PC model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        fetch_err;
    logic        misalign_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_pc;
    // Redirect values applied on the accept cycle of the next fetch.
    logic        a_br, a_j, a_jr;
    logic [15:0] a_off;
    logic [25:0] a_idx;
    logic [31:0] a_tgt;

    fetch_unit u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .fetch_err     (fetch_err),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference next-PC computed directly from the redirect rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur);
        logic [31:0] seq;
        int          soff;
        seq = cur + 32'd4;
        if (a_jr) return a_tgt & 32'hFFFF_FFFC;
        if (a_j) return (seq & 32'hF000_0000) | ({6'd0, a_idx} * 32'd4);
        if (a_br) begin
            soff = int'($signed(a_off));
            return seq + 32'(soff * 4);
        end
        return seq;
    endfunction

    task automatic set_redirect(input logic br, input logic [15:0] off, input logic j,
                                input logic [25:0] idx, input logic jrv, input logic [31:0] tgt);
        a_br = br; a_off = off; a_j = j; a_idx = idx; a_jr = jrv; a_tgt = tgt;
    endtask

    task automatic junk_redirect();
        branch_taken  = 1'($urandom);
        branch_offset = 16'($urandom);
        jump          = 1'($urandom);
        jump_index    = 26'($urandom);
        jr            = 1'($urandom);
        jr_target     = $urandom;
    endtask

    // Entered at a negedge with the DUT in REQ; leaves at a negedge back in REQ.
    task automatic do_fetch(input int waits, input int stalls);
        logic [31:0] data;
        logic        exp_mis;
        data = $urandom;
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            chk("req_wait", imem_req, 1);
            chk("addr_wait", imem_addr, model_pc);
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        chk("req", imem_req, 1);
        chk("addr", imem_addr, model_pc);
        chk("valid_in_req", instr_valid, 0);
        @(negedge clk);
        for (int i = 0; i <= stalls; i++) begin
            // Acks and redirects outside their window must be ignored.
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            junk_redirect();
            instr_ready = 1'b0;
            chk("valid", instr_valid, 1);
            chk("instr", instruction, data);
            chk("pc", pc, model_pc);
            chk("pc_plus4", pc_plus4, model_pc + 32'd4);
            chk("req_in_hold", imem_req, 0);
            if (i < stalls) @(negedge clk);
        end
        instr_ready   = 1'b1;
        branch_taken  = a_br;
        branch_offset = a_off;
        jump          = a_j;
        jump_index    = a_idx;
        jr            = a_jr;
        jr_target     = a_tgt;
        exp_mis       = a_jr && (a_tgt[1:0] != 2'b00);
        #1;
        chk("misalign_accept", misalign_err, exp_mis);
        @(negedge clk);
        model_pc    = model_next(model_pc);
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        junk_redirect();
        chk("misalign_after", misalign_err, 0);
        set_redirect(0, 16'h0, 0, 26'h0, 0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_pc4"}, pc_plus4, 32'h4);
        chk({tag, "_instr"}, instruction, 32'h0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_ferr"}, fetch_err, 0);
        chk({tag, "_mis"}, misalign_err, 0);
    endtask

    initial begin
        int kind;
        rst_n = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_offset = '0; jump = 1'b0; jump_index = '0;
        jr = 1'b0; jr_target = '0;
        set_redirect(0, 16'h0, 0, 26'h0, 0, 32'h0);
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("rst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("idle_req", imem_req, 0);
        @(negedge clk);
        model_pc = 32'h0;

        // Zero-wait sequential stream: 0, 4, 8, 12.
        for (int n = 0; n < 4; n++) do_fetch(0, 0);
        chk("seq_addr", imem_addr, 32'h10);

        // Branch backwards from 0x100.
        set_redirect(0, 16'h0, 0, 26'h0, 1, 32'h0000_0100);
        do_fetch(1, 0);
        chk("jr_to_100", imem_addr, 32'h100);
        set_redirect(1, 16'hFFFE, 0, 26'h0, 0, 32'h0);
        do_fetch(0, 1);
        chk("branch_back", imem_addr, 32'h0FC);

        // Jump beats branch in the same accept cycle.
        set_redirect(0, 16'h0, 0, 26'h0, 1, 32'h4000_0010);
        do_fetch(0, 0);
        set_redirect(1, 16'h0100, 1, 26'h000_0040, 0, 32'h0);
        do_fetch(2, 0);
        chk("jump_wins", imem_addr, 32'h4000_0100);

        // Misaligned jr.
        set_redirect(1, 16'h0010, 1, 26'h1, 1, 32'h0000_0203);
        do_fetch(0, 0);
        chk("jr_misaligned", imem_addr, 32'h200);

        // Wrap at the top of the address space, and the longest legal wait.
        set_redirect(0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC);
        do_fetch(0, 0);
        do_fetch(14, 0);
        chk("wrap", imem_addr, 32'h0);

        // Randomized fetches with weighted redirect kinds.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            set_redirect(1'($urandom), 16'($urandom), 1'($urandom), 26'($urandom),
                         1'($urandom), $urandom);
            if (kind < 2) a_jr = 1'b1;
            else if (kind < 4) begin a_jr = 1'b0; a_j = 1'b1; end
            else if (kind < 7) begin a_jr = 1'b0; a_j = 1'b0; a_br = 1'b1; end
            else begin a_jr = 1'b0; a_j = 1'b0; a_br = 1'b0; end
            do_fetch(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
        end

        // Timeout: 15 REQ cycles without ack, then sticky error.
        imem_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_req", imem_req, 1);
            chk("to_ferr_low", fetch_err, 0);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            chk("err_ferr", fetch_err, 1);
            chk("err_req", imem_req, 0);
            chk("err_valid", instr_valid, 0);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        rst_n = 1'b0;
        #1 check_reset_outputs("err_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_pc = 32'h0;
        do_fetch(0, 0);

        // Reset mid-REQ with an ack arriving during the IDLE cycle after release.
        chk("mid_req", imem_req, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_instr", instruction, 32'h0);
        chk("late_valid", instr_valid, 0);
        chk("late_addr", imem_addr, 32'h0);
        model_pc = 32'h0;
        do_fetch(1, 0);
        do_fetch(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
